// File: rtl/stage_scheduler.sv
// Game-flow controller: stage sequencing, enemy spawn pulses, scoring, lives.
// Optional STAGE_SCHED_SFX_EN adds a one-cycle sfx_req pulse on kills and player damage.
module stage_scheduler #(
  parameter int FLY_COUNT      = 4,
  parameter int MOSQUITO_COUNT = 12,
  parameter int START_LIVES    = 3,
  parameter int MAX_STAGE      = 8,
  parameter int INTRO_FRAMES   = 60,
  parameter int CLEAR_FRAMES   = 90,
  parameter int INVULN_FRAMES  = 120,
  parameter int FLY_POINTS     = 10,
  parameter int MOSQ_POINTS    = 5
) (
  input  logic                      clk25,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      frame_tick,
  input  logic [FLY_COUNT-1:0]      fly_hit,
  input  logic [FLY_COUNT-1:0]      fly_alive,
  input  logic [MOSQUITO_COUNT-1:0] mosquito_hit,
  input  logic [MOSQUITO_COUNT-1:0] mosquito_alive,
  input  logic                      player_hit,
  output logic                      spawn_fly,
  output logic                      spawn_mosquito,
  output logic [3:0]                stage,
  output logic [15:0]               score,
  output logic [1:0]                lives,
  output logic [2:0]                game_state,
  output logic                      play_en
`ifdef STAGE_SCHED_SFX_EN
  ,
  output logic                      sfx_req
`endif
);

  localparam logic [2:0] S_TITLE = 3'd0;
  localparam logic [2:0] S_INTRO = 3'd1;
  localparam logic [2:0] S_SPAWN = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;
  localparam logic [2:0] S_WIN   = 3'd6;

  localparam int FC_MAX = (INTRO_FRAMES > CLEAR_FRAMES) ? INTRO_FRAMES : CLEAR_FRAMES;
  localparam int FCW    = $clog2(FC_MAX + 1);
  localparam int IVW    = $clog2(INVULN_FRAMES + 1);

  logic [2:0]     state;
  logic           start_d;
  logic [FCW-1:0] fc;
  logic [IVW-1:0] invuln;
  logic [16:0]    delta;
  logic [16:0]    sum;
  logic           start_edge;
  logic           hit_ok;
  logic           wave_clear;
  logic [3:0]     stage_inc;

  always_comb begin
    delta = '0;
    for (int i = 0; i < FLY_COUNT; i++)
      if (fly_hit[i]) delta = delta + 17'(FLY_POINTS);
    for (int i = 0; i < MOSQUITO_COUNT; i++)
      if (mosquito_hit[i]) delta = delta + 17'(MOSQ_POINTS);
  end

  assign sum        = {1'b0, score} + delta;
  assign start_edge = start & ~start_d;
  assign hit_ok     = (state == S_PLAY) && player_hit && (invuln == '0) && (lives != 2'd0);
  // Mosquitoes only take part in a wave from stage 2 onward.
  assign wave_clear = frame_tick && (fly_alive == '0) &&
                      ((stage < 4'd2) || (mosquito_alive == '0));
  assign stage_inc  = (stage < 4'(MAX_STAGE)) ? stage + 4'd1 : stage;

  assign game_state = state;
  assign play_en    = (state == S_PLAY);

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state          <= S_TITLE;
      start_d        <= 1'b0;
      fc             <= '0;
      invuln         <= '0;
      stage          <= 4'd0;
      score          <= 16'd0;
      lives          <= 2'd0;
      spawn_fly      <= 1'b0;
      spawn_mosquito <= 1'b0;
    end else begin
      start_d        <= start;
      spawn_fly      <= 1'b0;
      spawn_mosquito <= 1'b0;
      if (frame_tick && invuln != '0) invuln <= invuln - IVW'(1);
      case (state)
        S_TITLE, S_OVER, S_WIN: begin
          if (start_edge) begin
            state  <= S_INTRO;
            score  <= 16'd0;
            stage  <= 4'd1;
            lives  <= 2'(START_LIVES);
            invuln <= '0;
            fc     <= '0;
          end
        end
        S_INTRO: begin
          if (frame_tick) begin
            if (fc == FCW'(INTRO_FRAMES - 1)) begin
              fc             <= '0;
              state          <= S_SPAWN;
              spawn_fly      <= 1'b1;
              spawn_mosquito <= (stage >= 4'd2);
            end else begin
              fc <= fc + FCW'(1);
            end
          end
        end
        S_SPAWN: begin
          if (frame_tick) state <= S_PLAY;
        end
        S_PLAY: begin
          score <= sum[16] ? 16'hFFFF : sum[15:0];
          if (hit_ok) begin
            lives  <= lives - 2'd1;
            invuln <= IVW'(INVULN_FRAMES);
          end
          // A fatal hit outranks a simultaneous wave clear.
          if (hit_ok && lives == 2'd1) begin
            state <= S_OVER;
          end else if (wave_clear) begin
            state <= (stage >= 4'(MAX_STAGE)) ? S_WIN : S_CLEAR;
            fc    <= '0;
          end
        end
        S_CLEAR: begin
          if (frame_tick) begin
            if (fc == FCW'(CLEAR_FRAMES - 1)) begin
              fc             <= '0;
              stage          <= stage_inc;
              state          <= S_SPAWN;
              spawn_fly      <= 1'b1;
              spawn_mosquito <= (stage_inc >= 4'd2);
            end else begin
              fc <= fc + FCW'(1);
            end
          end
        end
        default: state <= S_TITLE;
      endcase
    end
  end

`ifdef STAGE_SCHED_SFX_EN
  always_ff @(posedge clk25) begin
    if (!rst_n) sfx_req <= 1'b0;
    else        sfx_req <= hit_ok || ((state == S_PLAY) && (delta != '0));
  end
`endif

endmodule

// File: tb/tb_stage_scheduler.sv
// Directed bench for stage_scheduler with a per-cycle behavioural model and scoreboard.
module tb_stage_scheduler;
  localparam int FC = 4, MC = 12, SL = 3, MS = 8, IF_ = 60, CF = 90, IV = 120, FP = 10, MP = 5;
  localparam int TITLE = 0, INTRO = 1, SPAWN = 2, PLAY = 3, CLEAR = 4, OVER = 5, WIN = 6;

  logic          clk25 = 1'b0;
  logic          rst_n, start, frame_tick, player_hit;
  logic [FC-1:0] fly_hit, fly_alive;
  logic [MC-1:0] mosquito_hit, mosquito_alive;
  logic          spawn_fly, spawn_mosquito, play_en;
  logic [3:0]    stage;
  logic [15:0]   score;
  logic [1:0]    lives;
  logic [2:0]    game_state;
`ifdef STAGE_SCHED_SFX_EN
  logic          sfx_req;
`endif

  int n_checks = 0;
  int n_err = 0;

  stage_scheduler #(
    .FLY_COUNT(FC), .MOSQUITO_COUNT(MC), .START_LIVES(SL), .MAX_STAGE(MS),
    .INTRO_FRAMES(IF_), .CLEAR_FRAMES(CF), .INVULN_FRAMES(IV),
    .FLY_POINTS(FP), .MOSQ_POINTS(MP)
  ) dut (
    .clk25(clk25), .rst_n(rst_n), .start(start), .frame_tick(frame_tick),
    .fly_hit(fly_hit), .fly_alive(fly_alive),
    .mosquito_hit(mosquito_hit), .mosquito_alive(mosquito_alive),
    .player_hit(player_hit),
    .spawn_fly(spawn_fly), .spawn_mosquito(spawn_mosquito),
    .stage(stage), .score(score), .lives(lives),
    .game_state(game_state), .play_en(play_en)
`ifdef STAGE_SCHED_SFX_EN
    , .sfx_req(sfx_req)
`endif
  );

  always #20 clk25 = ~clk25;

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: game rules expressed on plain integers.
  int m_st, m_stage, m_score, m_lives, m_inv, m_frames;
  bit m_prev_start, m_spf, m_spm, m_sfx, m_ok;
  initial m_ok = 1'b0;

  always @(posedge clk25) begin : model
    int  pts;
    bit  took_hit, cleared, fire;
    if (!rst_n) begin
      m_st = TITLE; m_stage = 0; m_score = 0; m_lives = 0; m_inv = 0; m_frames = 0;
      m_prev_start = 0; m_spf = 0; m_spm = 0; m_sfx = 0; m_ok = 1'b1;
    end else begin
      pts      = $countones(fly_hit) * FP + $countones(mosquito_hit) * MP;
      fire     = start && !m_prev_start;
      m_prev_start = start;
      took_hit = (m_st == PLAY) && player_hit && (m_inv == 0);
      cleared  = frame_tick && (fly_alive == 0) && (m_stage < 2 || mosquito_alive == 0);
      m_spf = 0; m_spm = 0; m_sfx = 0;
      if (frame_tick && m_inv > 0) m_inv--;
      if (m_st == TITLE || m_st == OVER || m_st == WIN) begin
        if (fire) begin
          m_st = INTRO; m_score = 0; m_stage = 1; m_lives = SL; m_inv = 0; m_frames = 0;
        end
      end else if (m_st == INTRO || m_st == CLEAR) begin
        if (frame_tick) begin
          m_frames++;
          if (m_frames == ((m_st == INTRO) ? IF_ : CF)) begin
            if (m_st == CLEAR && m_stage < MS) m_stage++;
            m_frames = 0; m_st = SPAWN; m_spf = 1; m_spm = (m_stage >= 2);
          end
        end
      end else if (m_st == SPAWN) begin
        if (frame_tick) m_st = PLAY;
      end else if (m_st == PLAY) begin
        m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
        m_sfx   = (pts != 0) || took_hit;
        if (took_hit) begin m_lives--; m_inv = IV; end
        if (took_hit && m_lives == 0) m_st = OVER;
        else if (cleared) begin m_st = (m_stage == MS) ? WIN : CLEAR; m_frames = 0; end
      end
    end
  end

  always @(negedge clk25) begin
    if (m_ok) begin
      chk("game_state", int'(game_state), m_st);
      chk("stage", int'(stage), m_stage);
      chk("score", int'(score), m_score);
      chk("lives", int'(lives), m_lives);
      chk("spawn_fly", int'(spawn_fly), int'(m_spf));
      chk("spawn_mosquito", int'(spawn_mosquito), int'(m_spm));
      chk("play_en", int'(play_en), int'(m_st == PLAY));
`ifdef STAGE_SCHED_SFX_EN
      chk("sfx_req", int'(sfx_req), int'(m_sfx));
`endif
    end
  end

  task automatic cyc();
    @(negedge clk25);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      repeat (3) cyc();
    end
  endtask

  task automatic restart();
    start = 1'b0; cyc(); start = 1'b1; cyc();
  endtask

  task automatic to_play();
    frames(IF_);
    fly_alive = '1; mosquito_alive = '1;
    frames(1);
  endtask

  task automatic clear_wave();
    fly_alive = '0; mosquito_alive = '0;
    frames(1);
    frames(CF);
    fly_alive = '1; mosquito_alive = '1;
    frames(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; frame_tick = 1'b0; player_hit = 1'b0;
    fly_hit = '0; fly_alive = '0; mosquito_hit = '0; mosquito_alive = '0;
    repeat (3) cyc();
    chk("rst state", int'(game_state), TITLE);
    chk("rst stage", int'(stage), 0);
    chk("rst lives", int'(lives), 0);
    chk("rst play_en", int'(play_en), 0);
    rst_n = 1'b1; cyc();

    // Game start and intro timing
    start = 1'b1; cyc();
    chk("start state", int'(game_state), INTRO);
    chk("start stage", int'(stage), 1);
    chk("start lives", int'(lives), 3);
    chk("start score", int'(score), 0);
    frames(IF_ - 1);
    chk("intro hold", int'(game_state), INTRO);
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    chk("spawn state", int'(game_state), SPAWN);
    chk("spawn_fly pulse", int'(spawn_fly), 1);
    chk("spawn_mosq stage1", int'(spawn_mosquito), 0);
    cyc();
    chk("spawn_fly single", int'(spawn_fly), 0);
    fly_alive = '1; mosquito_alive = '1;
    frames(1);
    chk("play state", int'(game_state), PLAY);
    chk("play_en", int'(play_en), 1);
    start = 1'b0; cyc(); start = 1'b1; cyc();
    chk("start ignored", int'(game_state), PLAY);

    // Stage 1 clears on flies alone; kills during CLEAR are discarded
    fly_alive = '0;
    frames(1);
    chk("clear state", int'(game_state), CLEAR);
    fly_hit = 4'b0101; mosquito_hit = 12'h008; cyc();
    fly_hit = '0; mosquito_hit = '0; cyc();
    chk("score in clear", int'(score), 0);
    mosquito_alive = '0;
    frames(CF);
    chk("stage2 spawn", int'(game_state), SPAWN);
    chk("stage2", int'(stage), 2);
    fly_alive = '1; mosquito_alive = '1;
    frames(1);
    fly_hit = 4'b0101; mosquito_hit = 12'h008; cyc();
    fly_hit = '0; mosquito_hit = '0;
    chk("score +25", int'(score), 25);

    // Saturation: 25 + 655*100 + 5 = 65530, then +40 clamps
    fly_hit = '1; mosquito_hit = '1;
    repeat (655) cyc();
    fly_hit = '0; mosquito_hit = 12'h001; cyc();
    mosquito_hit = '0; cyc();
    chk("score near top", int'(score), 65530);
    fly_hit = 4'b1111; cyc(); fly_hit = '0;
    chk("score saturate", int'(score), 65535);
    fly_hit = '1; mosquito_hit = '1; cyc(); fly_hit = '0; mosquito_hit = '0;
    chk("score hold max", int'(score), 65535);

    // Player damage with invulnerability window
    player_hit = 1'b1; cyc(); player_hit = 1'b0;
    chk("lives after hit1", int'(lives), 2);
    frames(10);
    player_hit = 1'b1; cyc(); player_hit = 1'b0;
    chk("invuln ignores hit", int'(lives), 2);
    frames(IV - 9);
    player_hit = 1'b1; cyc(); player_hit = 1'b0;
    chk("lives after hit2", int'(lives), 1);

    // Stage 8 clear with a fatal hit on the same tick: OVER wins
    repeat (6) clear_wave();
    chk("reach stage 8", int'(stage), 8);
    fly_alive = '0; mosquito_alive = '0; frame_tick = 1'b1; player_hit = 1'b1; cyc();
    frame_tick = 1'b0; player_hit = 1'b0;
    chk("fatal beats win", int'(game_state), OVER);
    chk("lives zero", int'(lives), 0);

    // Second game: clearing stage 8 enters WIN
    restart();
    chk("restart stage", int'(stage), 1);
    chk("restart lives", int'(lives), 3);
    chk("restart score", int'(score), 0);
    to_play();
    repeat (7) clear_wave();
    fly_alive = '0; mosquito_alive = '0;
    frames(1);
    chk("win state", int'(game_state), WIN);
    frames(3);
    chk("win hold stage", int'(stage), 8);

    // Third game: reset in the middle of stage 5
    restart();
    to_play();
    repeat (4) clear_wave();
    chk("stage 5", int'(stage), 5);
    fly_hit = 4'b0011; cyc(); fly_hit = '0;
    chk("stage5 score", int'(score), 20);
    start = 1'b0; rst_n = 1'b0; cyc();
    chk("midrst state", int'(game_state), TITLE);
    chk("midrst stage", int'(stage), 0);
    chk("midrst score", int'(score), 0);
    chk("midrst play_en", int'(play_en), 0);
    chk("midrst spawn", int'(spawn_fly) + int'(spawn_mosquito), 0);
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post rst idle", int'(game_state), TITLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
